syncff_mchctrl: RTL and testbench

//  Single-clock, multi-channel FIFO controller that supersedes the per-FIFO write/read

---
 rtl/syncff_mchctrl_pkg.sv | 32 +++
 rtl/syncff_mchctrl_chptr.sv | 77 +++++++
 rtl/syncff_mchctrl.sv | 132 +++++++++++++
 tb/tb_syncff_mchctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/syncff_mchctrl_pkg.sv
// Shared definitions for the multi-channel FIFO controller.
//   Defaults for the per-channel depth and channel-count parameters.
//   Pointer helper functions for level, full and empty.
// The helpers work on a fixed-width container (PW_MAX bits).
// Callers zero-extend their ADDRB+1 bit pointers into it and pass ADDRB.
package syncff_mchctrl_pkg;

  localparam int unsigned DEF_ADDRB = 4;
  localparam int unsigned DEF_CHB   = 2;
  localparam int unsigned PW_MAX    = 16;

  // Occupancy as a modulo-2**(addrb+1) pointer difference.
  function automatic logic [PW_MAX-1:0] ptr_level_f(input logic [PW_MAX-1:0] wr,
                                                     input logic [PW_MAX-1:0] rd,
                                                     input int unsigned       addrb);
    logic [PW_MAX-1:0] mask;
    mask = (16'd1 << (addrb + 32'd1)) - 16'd1;
    return (wr - rd) & mask;
  endfunction

  // A level of exactly 2**addrb means the pointer MSBs differ and the slot bits match.
  function automatic logic ptr_full_f(input logic [PW_MAX-1:0] lvl,
                                      input int unsigned       addrb);
    return (lvl == (16'd1 << addrb));
  endfunction

  // Empty when both pointers coincide.
  function automatic logic ptr_empty_f(input logic [PW_MAX-1:0] lvl);
    return (lvl == 16'd0);
  endfunction

endpackage

// File: rtl/syncff_mchctrl_chptr.sv
// Per-channel pointer pair and status for one circular queue.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   inc_wr / inc_rd    advance the write / read pointer (already qualified)
//   flush              clear both pointers at the next edge (beats inc_*)
//   afthr              almost-full threshold
//   wrpnt / rdpnt      binary pointers, ADDRB+1 bits
//   level              wrpnt - rdpnt, 0..DEPTH
//   full / notempty / almost_full  status derived from the pointer registers
module syncff_mchctrl_chptr
  import syncff_mchctrl_pkg::*;
#(
  parameter int unsigned ADDRB = DEF_ADDRB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_wr,
  input  logic             inc_rd,
  input  logic             flush,
  input  logic [ADDRB:0]   afthr,
  output logic [ADDRB:0]   wrpnt,
  output logic [ADDRB:0]   rdpnt,
  output logic [ADDRB:0]   level,
  output logic             full,
  output logic             notempty,
  output logic             almost_full
);

  localparam logic [ADDRB:0] PTR_ONE  = (ADDRB+1)'(1);
  localparam logic [ADDRB:0] PTR_ZERO = (ADDRB+1)'(0);

  logic [ADDRB:0]    wrpnt_q, wrpnt_d;
  logic [ADDRB:0]    rdpnt_q, rdpnt_d;
  logic [PW_MAX-1:0] level_w;

  // Next-state pointers: flush clears, otherwise step on qualified requests.
  always_comb begin
    wrpnt_d = wrpnt_q;
    rdpnt_d = rdpnt_q;
    if (flush) begin
      wrpnt_d = PTR_ZERO;
      rdpnt_d = PTR_ZERO;
    end else begin
      if (inc_wr) begin
        wrpnt_d = wrpnt_q + PTR_ONE;
      end else begin
        wrpnt_d = wrpnt_q;
      end
      if (inc_rd) begin
        rdpnt_d = rdpnt_q + PTR_ONE;
      end else begin
        rdpnt_d = rdpnt_q;
      end
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrpnt_q <= PTR_ZERO;
      rdpnt_q <= PTR_ZERO;
    end else begin
      wrpnt_q <= wrpnt_d;
      rdpnt_q <= rdpnt_d;
    end
  end

  assign level_w     = ptr_level_f(PW_MAX'(wrpnt_q), PW_MAX'(rdpnt_q), ADDRB);
  assign level       = (ADDRB+1)'(level_w);
  assign full        = ptr_full_f(level_w, ADDRB);
  assign notempty    = ~ptr_empty_f(level_w);
  // afthr==0 is always met and afthr>DEPTH is never met, because level is 0..DEPTH.
  assign almost_full = (level >= afthr);
  assign wrpnt       = wrpnt_q;
  assign rdpnt       = rdpnt_q;

endmodule

// File: rtl/syncff_mchctrl.sv
// Multi-channel FIFO controller for NCH circular queues in one shared external RAM.
// The RAM address is {channel, slot}.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   fifowr/wrch, fiford/rdch     write/read requests and their channels
//   fifoflush/flushch            per-channel flush request
//   afthr                        global almost-full threshold
//   errclr                       clears the sticky ovf/udf flags
//   write/wraddr, read/rdaddr    RAM enables and addresses (same cycle as request)
//   fifofull/notempty/almost_full per-channel status
//   lensel/fifolen               level readout of the selected channel
//   ovf/udf                      sticky overflow/underflow
module syncff_mchctrl
  import syncff_mchctrl_pkg::*;
#(
  parameter int unsigned ADDRB = DEF_ADDRB,
  parameter int unsigned CHB   = DEF_CHB
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifowr,
  input  logic [CHB-1:0]       wrch,
  input  logic                 fiford,
  input  logic [CHB-1:0]       rdch,
  input  logic                 fifoflush,
  input  logic [CHB-1:0]       flushch,
  input  logic [ADDRB:0]       afthr,
  input  logic                 errclr,
  output logic                 write,
  output logic [CHB+ADDRB-1:0] wraddr,
  output logic                 read,
  output logic [CHB+ADDRB-1:0] rdaddr,
  output logic [(1<<CHB)-1:0]  fifofull,
  output logic [(1<<CHB)-1:0]  notempty,
  output logic [(1<<CHB)-1:0]  almost_full,
  input  logic [CHB-1:0]       lensel,
  output logic [ADDRB:0]       fifolen,
  output logic                 ovf,
  output logic                 udf
);

  localparam int unsigned NCH = 1 << CHB;

  logic [ADDRB:0] wrpnt_s [NCH];
  logic [ADDRB:0] rdpnt_s [NCH];
  logic [ADDRB:0] level_s [NCH];
  logic [NCH-1:0] inc_wr_s, inc_rd_s, flush_s;
  logic           wr_flushed_s, rd_flushed_s;
  logic           ovf_set_s, udf_set_s;
  logic           ovf_q, ovf_d, udf_q, udf_d;

  // A flush on the requested channel silently cancels the request.
  assign wr_flushed_s = fifoflush & (flushch == wrch);
  assign rd_flushed_s = fifoflush & (flushch == rdch);

  // Acceptance uses pre-cycle status only, so same-channel write/read never bypass.
  assign write = ~rst & fifowr & ~fifofull[wrch] & ~wr_flushed_s;
  assign read  = ~rst & fiford & notempty[rdch]  & ~rd_flushed_s;

  assign wraddr  = {wrch, ADDRB'(wrpnt_s[wrch])};
  assign rdaddr  = {rdch, ADDRB'(rdpnt_s[rdch])};
  assign fifolen = level_s[lensel];

  assign ovf_set_s = fifowr & fifofull[wrch]  & ~wr_flushed_s;
  assign udf_set_s = fiford & ~notempty[rdch] & ~rd_flushed_s;

  // Per-channel decode of accepted requests and flushes.
  always_comb begin
    inc_wr_s = '0;
    inc_rd_s = '0;
    flush_s  = '0;
    for (int i = 0; i < NCH; i++) begin
      inc_wr_s[i] = write & (wrch == CHB'(i));
      inc_rd_s[i] = read & (rdch == CHB'(i));
      flush_s[i]  = fifoflush & (flushch == CHB'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    syncff_mchctrl_chptr #(
      .ADDRB(ADDRB)
    ) u_chptr (
      .clk        (clk),
      .rst        (rst),
      .inc_wr     (inc_wr_s[g]),
      .inc_rd     (inc_rd_s[g]),
      .flush      (flush_s[g]),
      .afthr      (afthr),
      .wrpnt      (wrpnt_s[g]),
      .rdpnt      (rdpnt_s[g]),
      .level      (level_s[g]),
      .full       (fifofull[g]),
      .notempty   (notempty[g]),
      .almost_full(almost_full[g])
    );
  end

  // Sticky error flags: a new event wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (errclr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (udf_set_s) begin
      udf_d = 1'b1;
    end else if (errclr) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;

endmodule

// File: tb/tb_syncff_mchctrl.sv
module tb_syncff_mchctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifowr, fiford, fifoflush, errclr;
  logic [1:0] wrch, rdch, flushch, lensel;
  logic [4:0] afthr;
  logic       write, read, ovf, udf;
  logic [5:0] wraddr, rdaddr;
  logic [3:0] fifofull, notempty, almost_full;
  logic [4:0] fifolen;

  int tests = 0;
  int fails = 0;

  syncff_mchctrl dut (
    .clk(clk), .rst(rst), .fifowr(fifowr), .wrch(wrch), .fiford(fiford), .rdch(rdch),
    .fifoflush(fifoflush), .flushch(flushch), .afthr(afthr), .errclr(errclr),
    .write(write), .wraddr(wraddr), .read(read), .rdaddr(rdaddr),
    .fifofull(fifofull), .notempty(notempty), .almost_full(almost_full),
    .lensel(lensel), .fifolen(fifolen), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fifowr = 1'b0; fiford = 1'b0; fifoflush = 1'b0; errclr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle(); wrch = 2'd0; rdch = 2'd0; flushch = 2'd0; lensel = 2'd0;
    afthr = 5'd16;
    tick(); tick();
    // Requests are gated while rst is high.
    fifowr = 1'b1; wrch = 2'd1; fiford = 1'b1; rdch = 2'd1; #1;
    check("rst_gates_write", write, 1'b0);
    check("rst_gates_read", read, 1'b0);
    tick();
    rst = 1'b0; idle(); #1;
    check("reset_full", fifofull, 4'b0000);
    check("reset_notempty", notempty, 4'b0000);
    check("reset_len", fifolen, 5'd0);
    check("reset_ovf", ovf, 1'b0);
    check("reset_udf", udf, 1'b0);
    check("reset_af", almost_full, 4'b0000);

    // 1: fill ch1
    fifowr = 1'b1; wrch = 2'd1; lensel = 2'd1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("t1_write", write, 1'b1);
      check("t1_wraddr", wraddr, 6'h10 + 6'(i));
      tick();
    end
    #1;
    check("t1_full", fifofull, 4'b0010);
    check("t1_len", fifolen, 5'd16);
    check("t1_notempty", notempty, 4'b0010);
    check("t1_write17", write, 1'b0);
    tick(); idle(); #1;
    check("t1_ovf", ovf, 1'b1);
    check("t1_udf", udf, 1'b0);

    // 2: drain ch1
    fiford = 1'b1; rdch = 2'd1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("t2_read", read, 1'b1);
      check("t2_rdaddr", rdaddr, 6'h10 + 6'(i));
      tick();
    end
    #1;
    check("t2_notempty", notempty, 4'b0000);
    check("t2_read17", read, 1'b0);
    tick(); idle(); #1;
    check("t2_udf", udf, 1'b1);
    check("t2_ovf_kept", ovf, 1'b1);
    errclr = 1'b1; tick(); idle(); #1;
    check("t2_clr_ovf", ovf, 1'b0);
    check("t2_clr_udf", udf, 1'b0);

    // 3: ch2 steady state across pointer wrap
    fifowr = 1'b1; wrch = 2'd2; lensel = 2'd2;
    tick(); tick(); tick();
    fiford = 1'b1; rdch = 2'd2;
    for (int i = 0; i < 40; i++) begin
      #1;
      check("t3_len", fifolen, 5'd3);
      check("t3_write", write, 1'b1);
      check("t3_read", read, 1'b1);
      check("t3_rdaddr", rdaddr, {2'd2, 4'(i % 16)});
      check("t3_wraddr", wraddr, {2'd2, 4'((i + 3) % 16)});
      tick();
    end
    idle(); #1;
    check("t3_len_end", fifolen, 5'd3);

    // 4: ch0 full with same-cycle write and read
    fifowr = 1'b1; wrch = 2'd0; lensel = 2'd0;
    for (int i = 0; i < 16; i++) tick();
    idle(); #1;
    check("t4_full", fifofull, 4'b0001);
    fifowr = 1'b1; fiford = 1'b1; rdch = 2'd0; #1;
    check("t4_read", read, 1'b1);
    check("t4_write", write, 1'b0);
    check("t4_rdaddr", rdaddr, 6'h00);
    tick(); idle(); #1;
    check("t4_ovf", ovf, 1'b1);
    check("t4_len", fifolen, 5'd15);
    errclr = 1'b1; tick(); idle(); #1;
    check("t4_clr_ovf", ovf, 1'b0);

    // 5: almost_full threshold on ch3
    afthr = 5'd12; fifowr = 1'b1; wrch = 2'd3;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("t5_af_low", almost_full[3], 1'b0);
      tick();
    end
    idle(); #1;
    check("t5_af_high", almost_full[3], 1'b1);
    check("t5_af_vec", almost_full, 4'b1001);

    // Bring ch3 down to 5 entries.
    fiford = 1'b1; rdch = 2'd3;
    for (int i = 0; i < 7; i++) tick();
    idle(); lensel = 2'd3; #1;
    check("t6_len5", fifolen, 5'd5);

    // 6: flush ch3 with same-cycle write ch3 and read ch0
    fifoflush = 1'b1; flushch = 2'd3; fifowr = 1'b1; wrch = 2'd3;
    fiford = 1'b1; rdch = 2'd0; #1;
    check("t6_write", write, 1'b0);
    check("t6_read", read, 1'b1);
    tick(); idle(); #1;
    check("t6_len0", fifolen, 5'd0);
    check("t6_ovf", ovf, 1'b0);
    check("t6_udf", udf, 1'b0);
    lensel = 2'd0; #1;
    check("t6_ch0_len", fifolen, 5'd14);

    // Flush on the read channel cancels the read without raising udf.
    fifoflush = 1'b1; flushch = 2'd2; fiford = 1'b1; rdch = 2'd2; #1;
    check("t6_flush_rd", read, 1'b0);
    tick(); idle(); lensel = 2'd2; #1;
    check("t6_ch2_len", fifolen, 5'd0);
    check("t6_udf_flush", udf, 1'b0);

    // Raise udf, then reset mid-stream.
    fiford = 1'b1; rdch = 2'd1; tick(); idle(); #1;
    check("t6_udf_set", udf, 1'b1);
    rst = 1'b1; fifowr = 1'b1; wrch = 2'd1; fiford = 1'b1; rdch = 2'd0; #1;
    check("t6_rst_write", write, 1'b0);
    check("t6_rst_read", read, 1'b0);
    tick(); rst = 1'b0; idle(); #1;
    check("t6_rst_notempty", notempty, 4'b0000);
    check("t6_rst_full", fifofull, 4'b0000);
    check("t6_rst_ovf", ovf, 1'b0);
    check("t6_rst_udf", udf, 1'b0);
    for (int c = 0; c < 4; c++) begin
      lensel = 2'(c); #1;
      check("t6_rst_len", fifolen, 5'd0);
    end
    afthr = 5'd0; #1;
    check("t5_af_zero", almost_full, 4'hF);
    afthr = 5'd17; #1;
    check("t5_af_over", almost_full, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
